// File: rtl/sport_ctl_regs_mc.sv
// Multi-channel SPORT control register bank: AUTO plus double-buffered FSDIV/SCLKDIV/SCTL/MWORD
// with frame-aligned commit, MWORD preset, self-clearing PDFORCE and registered readback.
module sport_ctl_regs_mc #(
    parameter int          NCH          = 2,
    parameter int          CW           = 3,
    parameter logic [15:0] PRESET_FSDIV = 16'h00FF,
    parameter logic [15:0] PRESET_SCTL  = 16'h4B0F,
    parameter logic [15:0] PRESET_MWORD = 16'h4000
) (
    input  logic              DSPCLK,
    input  logic              RSTn,
    input  logic              WE,
    input  logic              RE,
    input  logic [CW-1:0]     CH_SEL,
    input  logic [2:0]        REG_SEL,
    input  logic [15:0]       DMD,
    input  logic [NCH-1:0]    FS_BND,
    output logic [15:0]       DMD_do,
    output logic              RD_VLD,
    output logic [16*NCH-1:0] AUTO_ACT,
    output logic [16*NCH-1:0] FSDIV_ACT,
    output logic [16*NCH-1:0] SCLKDIV_ACT,
    output logic [16*NCH-1:0] SCTL_ACT,
    output logic [16*NCH-1:0] MWORD_ACT,
    output logic [NCH-1:0]    UPD_PEND
);

    typedef enum logic [2:0] {
        R_AUTO    = 3'd0,
        R_FSDIV   = 3'd1,
        R_SCLKDIV = 3'd2,
        R_SCTL    = 3'd3,
        R_MWORD   = 3'd4
    } reg_sel_e;

    localparam logic [15:0] MWORD_KEEP = 16'hE0FF;

    logic [15:0] auto_r     [NCH];
    logic [15:0] sh_fsdiv   [NCH];
    logic [15:0] sh_sclkdiv [NCH];
    logic [15:0] sh_sctl    [NCH];
    logic [15:0] sh_mword   [NCH];
    logic [15:0] ac_fsdiv   [NCH];
    logic [15:0] ac_sclkdiv [NCH];
    logic [15:0] ac_sctl    [NCH];
    logic [15:0] ac_mword   [NCH];
    logic [NCH-1:0] pend;
    logic [15:0] rd_data;

    // Commit uses pre-edge shadows; a same-edge write overrides the shadow and re-arms pend.
    always_ff @(posedge DSPCLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int unsigned c = 0; c < NCH; c++) begin
                auto_r[c]     <= '0;
                sh_fsdiv[c]   <= '0;
                sh_sclkdiv[c] <= '0;
                sh_sctl[c]    <= '0;
                sh_mword[c]   <= '0;
                ac_fsdiv[c]   <= '0;
                ac_sclkdiv[c] <= '0;
                ac_sctl[c]    <= '0;
                ac_mword[c]   <= '0;
            end
            pend   <= '0;
            DMD_do <= '0;
            RD_VLD <= 1'b0;
        end else begin
            RD_VLD <= RE;
            if (RE)
                DMD_do <= rd_data;
            for (int unsigned c = 0; c < NCH; c++) begin
                if (pend[c] && (FS_BND[c] || !auto_r[c][0])) begin
                    ac_fsdiv[c]   <= sh_fsdiv[c];
                    ac_sclkdiv[c] <= sh_sclkdiv[c];
                    ac_sctl[c]    <= sh_sctl[c];
                    ac_mword[c]   <= sh_mword[c];
                    pend[c]       <= 1'b0;
                end
                auto_r[c][13] <= 1'b0;
                if (WE && CH_SEL == CW'(c)) begin
                    case (REG_SEL)
                        R_AUTO:    auto_r[c] <= DMD;
                        R_FSDIV:   begin sh_fsdiv[c]   <= DMD; pend[c] <= 1'b1; end
                        R_SCLKDIV: begin sh_sclkdiv[c] <= DMD; pend[c] <= 1'b1; end
                        R_SCTL:    begin sh_sctl[c]    <= DMD; pend[c] <= 1'b1; end
                        R_MWORD: begin
                            if (DMD[14]) begin
                                sh_fsdiv[c] <= PRESET_FSDIV;
                                sh_sctl[c]  <= PRESET_SCTL;
                                sh_mword[c] <= (PRESET_MWORD | (DMD & 16'h6000)) & MWORD_KEEP;
                            end else begin
                                sh_mword[c] <= DMD & MWORD_KEEP;
                            end
                            pend[c] <= 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            if (CH_SEL == CW'(c)) begin
                case (REG_SEL)
                    R_AUTO:    rd_data = auto_r[c];
                    R_FSDIV:   rd_data = sh_fsdiv[c];
                    R_SCLKDIV: rd_data = sh_sclkdiv[c];
                    R_SCTL:    rd_data = sh_sctl[c];
                    R_MWORD:   rd_data = {sh_mword[c][15:13], pend[c], 4'b0000, sh_mword[c][7:0]};
                    default:   rd_data = '0;
                endcase
            end
        end
    end

    always_comb begin
        AUTO_ACT    = '0;
        FSDIV_ACT   = '0;
        SCLKDIV_ACT = '0;
        SCTL_ACT    = '0;
        MWORD_ACT   = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            AUTO_ACT[16*c +: 16]    = auto_r[c];
            FSDIV_ACT[16*c +: 16]   = ac_fsdiv[c];
            SCLKDIV_ACT[16*c +: 16] = ac_sclkdiv[c];
            SCTL_ACT[16*c +: 16]    = ac_sctl[c];
            MWORD_ACT[16*c +: 16]   = ac_mword[c];
        end
    end

    assign UPD_PEND = pend;

endmodule

// File: tb/tb_sport_ctl_regs_mc.sv
// Directed bench for sport_ctl_regs_mc (NCH=2): hand-computed vectors, one checking task.
module tb_sport_ctl_regs_mc;

    logic        DSPCLK;
    logic        RSTn;
    logic        WE;
    logic        RE;
    logic [2:0]  CH_SEL;
    logic [2:0]  REG_SEL;
    logic [15:0] DMD;
    logic [1:0]  FS_BND;
    logic [15:0] DMD_do;
    logic        RD_VLD;
    logic [31:0] AUTO_ACT;
    logic [31:0] FSDIV_ACT;
    logic [31:0] SCLKDIV_ACT;
    logic [31:0] SCTL_ACT;
    logic [31:0] MWORD_ACT;
    logic [1:0]  UPD_PEND;

    int n_vec;
    int n_err;

    sport_ctl_regs_mc #(.NCH(2), .CW(3)) dut (
        .DSPCLK      (DSPCLK),
        .RSTn        (RSTn),
        .WE          (WE),
        .RE          (RE),
        .CH_SEL      (CH_SEL),
        .REG_SEL     (REG_SEL),
        .DMD         (DMD),
        .FS_BND      (FS_BND),
        .DMD_do      (DMD_do),
        .RD_VLD      (RD_VLD),
        .AUTO_ACT    (AUTO_ACT),
        .FSDIV_ACT   (FSDIV_ACT),
        .SCLKDIV_ACT (SCLKDIV_ACT),
        .SCTL_ACT    (SCTL_ACT),
        .MWORD_ACT   (MWORD_ACT),
        .UPD_PEND    (UPD_PEND)
    );

    initial DSPCLK = 1'b0;
    always #5 DSPCLK = ~DSPCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge DSPCLK);
        #1;
    endtask

    task automatic wr(input logic [2:0] ch, input logic [2:0] rs, input logic [15:0] d);
        WE = 1'b1; CH_SEL = ch; REG_SEL = rs; DMD = d;
        tick();
        WE = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [2:0] ch, input logic [2:0] rs,
                      input logic [15:0] exp_v);
        RE = 1'b1; CH_SEL = ch; REG_SEL = rs;
        tick();
        RE = 1'b0;
        check({tag, "_data"}, {16'h0, DMD_do}, {16'h0, exp_v});
        check({tag, "_vld"}, {31'h0, RD_VLD}, 32'h1);
        tick();
        check({tag, "_vld_drop"}, {31'h0, RD_VLD}, 32'h0);
        check({tag, "_hold"}, {16'h0, DMD_do}, {16'h0, exp_v});
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        RSTn = 1'b0; WE = 1'b0; RE = 1'b0; CH_SEL = '0; REG_SEL = '0; DMD = '0; FS_BND = '0;
        #3;
        check("rst_auto", AUTO_ACT, 32'h0);
        check("rst_fsdiv", FSDIV_ACT, 32'h0);
        check("rst_pend", {30'h0, UPD_PEND}, 32'h0);
        check("rst_vld", {31'h0, RD_VLD}, 32'h0);
        #19 RSTn = 1'b1;

        for (int unsigned r = 0; r < 5; r++) begin
            rd("rst_rd_ch0", 3'd0, 3'(r), 16'h0000);
            rd("rst_rd_ch1", 3'd1, 3'(r), 16'h0000);
        end

        // SPEN=0: commit one edge after the write
        wr(3'd1, 3'd3, 16'h1234);
        check("sctl1_pend", {30'h0, UPD_PEND}, 32'h2);
        check("sctl1_pre", {16'h0, SCTL_ACT[31:16]}, 32'h0);
        tick();
        check("sctl1_act", {16'h0, SCTL_ACT[31:16]}, 32'h1234);
        check("sctl1_pend_clr", {30'h0, UPD_PEND}, 32'h0);

        // SPEN=1: wait for frame boundary
        wr(3'd0, 3'd0, 16'h0001);
        check("auto0", {16'h0, AUTO_ACT[15:0]}, 32'h0001);
        wr(3'd0, 3'd1, 16'h0040);
        tick();
        check("fsdiv0_hold", {16'h0, FSDIV_ACT[15:0]}, 32'h0);
        check("fsdiv0_pend", {30'h0, UPD_PEND}, 32'h1);
        rd("mword_pend", 3'd0, 3'd4, 16'h1000);
        FS_BND = 2'b01;
        tick();
        FS_BND = 2'b00;
        check("fsdiv0_commit", {16'h0, FSDIV_ACT[15:0]}, 32'h0040);
        check("fsdiv0_pend_clr", {30'h0, UPD_PEND}, 32'h0);
        rd("mword_nopend", 3'd0, 3'd4, 16'h0000);
        rd("fsdiv0_rd", 3'd0, 3'd1, 16'h0040);

        // commit and write on the same edge
        wr(3'd0, 3'd1, 16'h0060);
        check("fsdiv0_60_wait", {16'h0, FSDIV_ACT[15:0]}, 32'h0040);
        FS_BND = 2'b01;
        wr(3'd0, 3'd1, 16'h0080);
        FS_BND = 2'b00;
        check("coll_act", {16'h0, FSDIV_ACT[15:0]}, 32'h0060);
        check("coll_pend", {30'h0, UPD_PEND}, 32'h1);
        FS_BND = 2'b01;
        tick();
        FS_BND = 2'b00;
        check("coll_next", {16'h0, FSDIV_ACT[15:0]}, 32'h0080);
        check("coll_pend_clr", {30'h0, UPD_PEND}, 32'h0);

        // preset, with a pending SCLKDIV commit landing on the preset edge
        wr(3'd0, 3'd0, 16'h0000);
        wr(3'd0, 3'd2, 16'h0033);
        wr(3'd0, 3'd4, 16'h6000);
        check("pre_sclk", {16'h0, SCLKDIV_ACT[15:0]}, 32'h0033);
        check("pre_fsdiv_old", {16'h0, FSDIV_ACT[15:0]}, 32'h0080);
        check("pre_pend", {30'h0, UPD_PEND}, 32'h1);
        tick();
        check("preset_fsdiv", {16'h0, FSDIV_ACT[15:0]}, 32'h00FF);
        check("preset_sctl", {16'h0, SCTL_ACT[15:0]}, 32'h4B0F);
        check("preset_mword", {16'h0, MWORD_ACT[15:0]}, 32'h6000);
        check("preset_sclk", {16'h0, SCLKDIV_ACT[15:0]}, 32'h0033);

        // MWORD [12:8] not stored
        wr(3'd0, 3'd4, 16'h1F2A);
        rd("mword_mask", 3'd0, 3'd4, 16'h102A);
        check("mword_mask_act", {16'h0, MWORD_ACT[15:0]}, 32'h002A);

        // PDFORCE self-clear
        wr(3'd0, 3'd0, 16'h2000);
        check("pdf_set", {16'h0, AUTO_ACT[15:0]}, 32'h2000);
        tick();
        check("pdf_clr", {16'h0, AUTO_ACT[15:0]}, 32'h0000);
        wr(3'd0, 3'd0, 16'h2000);
        wr(3'd0, 3'd0, 16'h2000);
        check("pdf_rewr", {16'h0, AUTO_ACT[15:0]}, 32'h2000);
        tick();
        check("pdf_clr2", {16'h0, AUTO_ACT[15:0]}, 32'h0000);

        // ignored writes and reserved reads
        wr(3'd2, 3'd1, 16'hFFFF);
        wr(3'd0, 3'd5, 16'hFFFF);
        check("ign_pend", {30'h0, UPD_PEND}, 32'h0);
        rd("rd_badch", 3'd2, 3'd1, 16'h0000);
        rd("rd_rsvd", 3'd0, 3'd5, 16'h0000);

        // read and write to the same register on the same edge
        RE = 1'b1;
        wr(3'd1, 3'd2, 16'h0055);
        RE = 1'b0;
        check("rw_old", {16'h0, DMD_do}, 32'h0000);
        rd("rw_new", 3'd1, 3'd2, 16'h0055);

        // asynchronous reset while a commit is pending
        wr(3'd0, 3'd0, 16'h0001);
        wr(3'd0, 3'd1, 16'h0099);
        check("arst_pre_pend", {30'h0, UPD_PEND}, 32'h1);
        #2 RSTn = 1'b0;
        #1;
        check("arst_pend", {30'h0, UPD_PEND}, 32'h0);
        check("arst_fsdiv", FSDIV_ACT, 32'h0);
        check("arst_sclk", SCLKDIV_ACT, 32'h0);
        check("arst_auto", AUTO_ACT, 32'h0);
        #1 RSTn = 1'b1;
        FS_BND = 2'b11;
        tick();
        FS_BND = 2'b00;
        tick();
        check("arst_nocommit", FSDIV_ACT, 32'h0);
        check("arst_nopend", {30'h0, UPD_PEND}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
